core_inst_sequencer: RTL



---
 rtl/core_inst_sequencer_if.sv | 23 ++
 rtl/core_inst_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/core_inst_sequencer_if.sv
// core_inst_sequencer_if: host/core-side bundle for the instruction sequencer.
// master = host driving start/combine/valids, slave = the sequencer.
interface core_inst_sequencer_if;
   logic        start;
   logic        combine;
   logic        load_valid;
   logic        load_ready;
   logic        fifo_valid;
   logic [26:0] inst;
   logic        busy;
   logic        done;
   logic [15:0] cycle_cnt;

   modport master (
      output start, combine, load_valid, fifo_valid,
      input  load_ready, inst, busy, done, cycle_cnt
   );

   modport slave (
      input  start, combine, load_valid, fifo_valid,
      output load_ready, inst, busy, done, cycle_cnt
   );
endinterface

// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: walks one pass of load/kload/exec/drain/norm phases.
// Optional busy-cycle counter enabled by defining SEQ_PERF_CNT_EN.
module core_inst_sequencer #(
   parameter int ROWS     = 8,
   parameter int KROWS    = 8,
   parameter int NORM_LAT = 2
) (
   input logic                 clk,
   input logic                 reset,
   core_inst_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_Q, S_LOAD_K, S_KLOAD, S_EXEC,
      S_DRAIN, S_ACC, S_SYNC, S_DIV, S_DONE
   } state_t;

   localparam logic [4:0] ROWS_N   = 5'(ROWS);
   localparam logic [4:0] ROWS_M1  = 5'(ROWS - 1);
   localparam logic [4:0] KROWS_M1 = 5'(KROWS - 1);
   localparam logic [4:0] LAT      = 5'(NORM_LAT);
   localparam logic [4:0] DIV_M1   = 5'(ROWS + NORM_LAT - 1);

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic        combine_q;
   logic [26:0] inst_c;
   logic [3:0]  nadd;

   assign nadd = cnt_q[3:0] - LAT[3:0];

   // Phase FSM: cnt_q indexes the row/beat within the current phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         combine_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (bus.start) begin
               combine_q <= bus.combine;
               cnt_q     <= '0;
               state_q   <= S_LOAD_Q;
            end
            S_LOAD_Q: if (bus.load_valid) begin
               if (cnt_q == ROWS_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_LOAD_K;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_LOAD_K: if (bus.load_valid) begin
               if (cnt_q == KROWS_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_KLOAD;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_KLOAD: begin
               if (cnt_q == KROWS_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_EXEC;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_EXEC: begin
               if (cnt_q == ROWS_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_DRAIN;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_DRAIN: if (bus.fifo_valid) begin
               if (cnt_q == ROWS_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_ACC;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_ACC: begin
               if (cnt_q == ROWS_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_SYNC;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_SYNC: state_q <= S_DIV;
            S_DIV: begin
               if (cnt_q == DIV_M1) begin
                  cnt_q   <= '0;
                  state_q <= S_DONE;
               end else cnt_q <= cnt_q + 5'd1;
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Instruction word decode from state, beat counter and captured combine.
   always_comb begin
      inst_c = '0;
      unique case (state_q)
         S_LOAD_Q: if (bus.load_valid) begin
            inst_c[4]     = 1'b1;
            inst_c[15:12] = cnt_q[3:0];
         end
         S_LOAD_K: if (bus.load_valid) begin
            inst_c[2]     = 1'b1;
            inst_c[15:12] = cnt_q[3:0];
         end
         S_KLOAD: begin
            inst_c[3]     = 1'b1;
            inst_c[6]     = 1'b1;
            inst_c[15:12] = cnt_q[3:0];
         end
         S_EXEC: begin
            inst_c[5]     = 1'b1;
            inst_c[7]     = 1'b1;
            inst_c[15:12] = cnt_q[3:0];
         end
         S_DRAIN: if (bus.fifo_valid) begin
            inst_c[16]   = 1'b1;
            inst_c[0]    = 1'b1;
            inst_c[11:8] = cnt_q[3:0];
         end
         S_ACC: begin
            inst_c[1]    = 1'b1;
            inst_c[18]   = 1'b1;
            inst_c[17]   = combine_q;
            inst_c[11:8] = cnt_q[3:0];
         end
         S_SYNC: inst_c[17] = combine_q;
         S_DIV: begin
            inst_c[17] = combine_q;
            if (cnt_q < ROWS_N) begin
               inst_c[1]    = 1'b1;
               inst_c[19]   = 1'b1;
               inst_c[11:8] = cnt_q[3:0];
            end
            if (cnt_q >= LAT) begin
               inst_c[22]    = 1'b1;
               inst_c[26:23] = nadd;
            end
         end
         default: inst_c = '0;
      endcase
   end

   assign bus.inst       = inst_c;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.load_ready = (state_q == S_LOAD_Q) || (state_q == S_LOAD_K);

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] cyc_q;

   // Busy-cycle counter: cleared on accepted start, saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (bus.start) cyc_q <= '0;
      end else if (cyc_q != 16'hFFFF) begin
         cyc_q <= cyc_q + 16'd1;
      end
   end

   assign bus.cycle_cnt = cyc_q;
`else
   assign bus.cycle_cnt = '0;
`endif

endmodule
